program_loader: RTL and testbench

- Upstream stage of the processor top level. Receives a program as a byte stream over a valid/ready handshake.
- Packs each group of three bytes into a 20-bit instruction and writes it into the processor's instruction memory through the user write port (in_data, write_memory, user_address).
- Asserts op to start execution once the whole program is written.
- Turns a host byte link (UART receiver or testbench) into a complete load-and-run sequence.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/program_loader.sv | 124 ++++++++++++
 tb/tb_program_loader.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states, widths, opcode field.
package loader_pkg;

    localparam int unsigned INSTR_W = 20;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam int unsigned OPC_MSB = 19;
    localparam int unsigned OPC_LSB = 16;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        B0    = 3'd1,
        B1    = 3'd2,
        B2    = 3'd3,
        WRITE = 3'd4,
        RUN   = 3'd5,
        ERR   = 3'd6
    } state_e;

endpackage

// File: rtl/program_loader.sv
// Receives a header + 3-byte-per-instruction stream, writes packed instructions
// into instruction memory, then raises op to start execution.
module program_loader
    import loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [BYTE_W-1:0]   rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic                abort,
    output logic [INSTR_W-1:0]  in_data,
    output logic                write_memory,
    output logic [ADDR_W-1:0]   user_address,
    output logic                op,
    output logic                loading,
    output logic                error
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [INSTR_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 wm_q, wm_d;
    logic                 op_q, op_d;
    logic                 rdy_q, rdy_d;
    logic                 load_q, load_d;
    logic                 err_q, err_d;
    logic                 accept;

    assign accept = rx_valid && rdy_q;

    // Next state, byte packing and address counting; output flags derive from next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        addr_d  = addr_q;

        if (abort) begin
            state_d = HDR;
            cnt_d   = '0;
            addr_d  = '0;
        end else begin
            case (state_q)
                HDR: if (accept) begin
                    if (rx_data == '0 || rx_data > BYTE_W'(DEPTH)) begin
                        state_d = ERR;
                    end else begin
                        cnt_d   = CNT_W'(rx_data);
                        addr_d  = '0;
                        state_d = B0;
                    end
                end
                B0: if (accept) begin
                    data_d[7:0] = rx_data;
                    state_d     = B1;
                end
                B1: if (accept) begin
                    data_d[15:8] = rx_data;
                    state_d      = B2;
                end
                B2: if (accept) begin
                    if (rx_data[7:4] != 4'd0) begin
                        state_d = ERR;
                    end else begin
                        data_d[OPC_MSB:OPC_LSB] = rx_data[3:0];
                        state_d                 = WRITE;
                    end
                end
                WRITE: begin
                    if (CNT_W'(addr_q) == cnt_q - CNT_W'(1)) begin
                        state_d = RUN;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = B0;
                    end
                end
                RUN:     state_d = RUN;
                ERR:     state_d = ERR;
                default: state_d = HDR;
            endcase
        end

        wm_d   = (state_d == WRITE);
        op_d   = (state_d == RUN);
        err_d  = (state_d == ERR);
        rdy_d  = (state_d == HDR) || (state_d == B0) || (state_d == B1) || (state_d == B2);
        load_d = (state_d == B0) || (state_d == B1) || (state_d == B2) || (state_d == WRITE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HDR;
            cnt_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            wm_q    <= 1'b0;
            op_q    <= 1'b0;
            rdy_q   <= 1'b1;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wm_q    <= wm_d;
            op_q    <= op_d;
            rdy_q   <= rdy_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    assign rx_ready     = rdy_q;
    assign in_data      = data_q;
    assign write_memory = wm_q;
    assign user_address = addr_q;
    assign op           = op_q;
    assign loading      = load_q;
    assign error        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a stream-level reference model.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        abort;
    logic [19:0] in_data;
    logic        write_memory;
    logic [3:0]  user_address;
    logic        op;
    logic        loading;
    logic        error;

    program_loader dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .abort        (abort),
        .in_data      (in_data),
        .write_memory (write_memory),
        .user_address (user_address),
        .op           (op),
        .loading      (loading),
        .error        (error)
    );

    always #5 clk = ~clk;

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          cyc = 0;
    int          last_wr_cyc = -1;
    int          op_rise_cyc = -1;
    bit          op_seen = 0;
    bit          overlap = 0;
    logic [7:0]  stim[$];
    logic [23:0] exp_wr[$];
    logic [23:0] obs_wr[$];
    logic [23:0] ref_wr[$];
    bit          exp_run, exp_err;

    // Observe write strobes ({address, data}) and the first cycle op is seen high.
    always @(negedge clk) begin
        cyc++;
        if (write_memory === 1'b1) begin
            obs_wr.push_back({user_address, in_data});
            last_wr_cyc = cyc;
        end
        if (op === 1'b1 && !op_seen) begin
            op_seen     = 1;
            op_rise_cyc = cyc;
        end
        if (write_memory === 1'b1 && op === 1'b1) overlap = 1;
    end

    // Reference: interpret the byte stream directly from the format rules.
    function automatic void model();
        int unsigned n;
        logic [7:0]  b0, b1, b2;
        exp_wr.delete();
        exp_run = 0;
        exp_err = 0;
        n = stim[0];
        if (n == 0 || n > 16) begin
            exp_err = 1;
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            if (1 + 3*i + 2 >= stim.size()) return;
            b0 = stim[1 + 3*i];
            b1 = stim[2 + 3*i];
            b2 = stim[3 + 3*i];
            if (b2 > 8'h0F) begin
                exp_err = 1;
                return;
            end
            exp_wr.push_back({4'(i), b2[3:0], b1, b0});
        end
        exp_run = 1;
    endfunction

    task automatic clear_mon();
        obs_wr.delete();
        op_seen     = 0;
        overlap     = 0;
        last_wr_cyc = -1;
        op_rise_cyc = -1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        k = 0;
        while (rx_ready !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk_cnt++;
        if (k >= 40) $display("FAIL send_timeout byte=%h rx_ready=%b required 1", b, rx_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic do_abort();
        @(negedge clk);
        rx_valid = 1'b0;
        abort    = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
    endtask

    task automatic drive_stream(input int gap, input int maxgap);
        int k;
        clear_mon();
        for (int i = 0; i < stim.size(); i++)
            send_byte(stim[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : gap);
        idle();
        k = 0;
        while (op !== 1'b1 && error !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk_cnt++;
        if (k >= 60) $display("FAIL stream_end_timeout op=%b error=%b required one high", op, error);
        else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; abort = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({rx_ready, write_memory, op, loading, error} !== 5'b10000)
            $display("FAIL reset_flags got %b required 10000", {rx_ready, write_memory, op, loading, error});
        else pass_cnt++;
        chk_cnt++;
        if ({user_address, in_data} !== 24'h0)
            $display("FAIL reset_addr_data got %h required 000000", {user_address, in_data});
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_abort();
        stim = '{8'h02, 8'h34, 8'h12, 8'h05, 8'h78, 8'h56, 8'h0A};
        exp_wr = '{24'h051234, 24'h1A5678};
        drive_stream(0, 0);
        chk_cnt++;
        if (obs_wr.size() != 2) $display("FAIL basic_nwrites got %0d required 2", obs_wr.size());
        else pass_cnt++;
        foreach (exp_wr[i]) begin
            logic [23:0] got;
            got = (i < obs_wr.size()) ? obs_wr[i] : 24'hxxxxxx;
            chk_cnt++;
            if (got !== exp_wr[i]) $display("FAIL basic_write%0d got %h required %h", i, got, exp_wr[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if ({op, rx_ready, error} !== 3'b100) $display("FAIL basic_run got op/rdy/err=%b required 100", {op, rx_ready, error});
        else pass_cnt++;
        chk_cnt++;
        if (op_rise_cyc !== last_wr_cyc + 1) $display("FAIL basic_op_latency got cyc %0d required %0d", op_rise_cyc, last_wr_cyc + 1);
        else pass_cnt++;
        chk_cnt++;
        if (overlap) $display("FAIL basic_overlap got 1 required 0");
        else pass_cnt++;
    endtask

    task automatic test_bad_header();
        logic [7:0] hdrs[2];
        hdrs[0] = 8'h00;
        hdrs[1] = 8'h11;
        foreach (hdrs[h]) begin
            do_abort();
            clear_mon();
            send_byte(hdrs[h], 0);
            chk_cnt++;
            if (error !== 1'b1) $display("FAIL hdr%h_error_next got %b required 1", hdrs[h], error);
            else pass_cnt++;
            idle();
            repeat (3) @(negedge clk);
            chk_cnt++;
            if ({obs_wr.size() == 0, op, rx_ready} !== 3'b100)
                $display("FAIL hdr%h_err_state got nowr/op/rdy=%b required 100", hdrs[h], {obs_wr.size() == 0, op, rx_ready});
            else pass_cnt++;
            do_abort();
            chk_cnt++;
            if ({error, rx_ready, loading, op} !== 4'b0100)
                $display("FAIL hdr%h_abort got err/rdy/load/op=%b required 0100", hdrs[h], {error, rx_ready, loading, op});
            else pass_cnt++;
        end
    endtask

    task automatic test_bad_nibble();
        do_abort();
        stim = '{8'h01, 8'($urandom), 8'($urandom), 8'h15};
        model();
        drive_stream(0, 0);
        chk_cnt++;
        if ({obs_wr.size() == 0, error, op, exp_err} !== 4'b1101)
            $display("FAIL nibble_err got nowr/err/op=%b required 110", {obs_wr.size() == 0, error, op});
        else pass_cnt++;
    endtask

    task automatic test_throttled();
        do_abort();
        stim.delete();
        stim.push_back(8'h03);
        for (int i = 0; i < 3; i++) begin
            stim.push_back(8'($urandom));
            stim.push_back(8'($urandom));
            stim.push_back(8'($urandom_range(0, 15)));
        end
        model();
        drive_stream(0, 0);
        ref_wr = obs_wr;
        do_abort();
        drive_stream(1, 0);
        chk_cnt++;
        if (obs_wr.size() != 3 || ref_wr.size() != 3)
            $display("FAIL throttle_nwrites got %0d/%0d required 3/3", ref_wr.size(), obs_wr.size());
        else pass_cnt++;
        foreach (exp_wr[i]) begin
            logic [23:0] g0, g1;
            g0 = (i < ref_wr.size()) ? ref_wr[i] : 24'hxxxxxx;
            g1 = (i < obs_wr.size()) ? obs_wr[i] : 24'hxxxxxx;
            chk_cnt++;
            if (g0 !== exp_wr[i] || g1 !== exp_wr[i])
                $display("FAIL throttle_write%0d got b2b %h gapped %h required %h", i, g0, g1, exp_wr[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (op !== 1'b1 || op_rise_cyc !== last_wr_cyc + 1)
            $display("FAIL throttle_op got op=%b rise %0d required 1 at %0d", op, op_rise_cyc, last_wr_cyc + 1);
        else pass_cnt++;
    endtask

    task automatic test_full();
        do_abort();
        stim.delete();
        stim.push_back(8'd16);
        for (int i = 0; i < 16; i++) begin
            stim.push_back(8'($urandom));
            stim.push_back(8'($urandom));
            stim.push_back(8'($urandom_range(0, 15)));
        end
        model();
        drive_stream(0, 0);
        chk_cnt++;
        if (obs_wr.size() != 16) $display("FAIL full_nwrites got %0d required 16", obs_wr.size());
        else pass_cnt++;
        foreach (exp_wr[i]) begin
            logic [23:0] got;
            got = (i < obs_wr.size()) ? obs_wr[i] : 24'hxxxxxx;
            chk_cnt++;
            if (got !== exp_wr[i]) $display("FAIL full_write%0d got %h required %h", i, got, exp_wr[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if ({op, user_address, overlap} !== {1'b1, 4'd15, 1'b0})
            $display("FAIL full_run got op=%b addr=%0d ovl=%b required 1 15 0", op, user_address, overlap);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int unsigned n;
            logic [7:0]  b2;
            do_abort();
            stim.delete();
            n = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255))
                                            : $urandom_range(1, 16);
            stim.push_back(8'(n));
            if (n >= 1 && n <= 16) begin
                for (int i = 0; i < int'(n); i++) begin
                    stim.push_back(8'($urandom));
                    stim.push_back(8'($urandom));
                    b2 = ($urandom_range(0, 11) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
                    stim.push_back(b2);
                    if (b2 > 8'h0F) break;
                end
            end
            model();
            drive_stream(0, 2);
            chk_cnt++;
            if (obs_wr.size() != exp_wr.size())
                $display("FAIL rand%0d_nwrites got %0d required %0d", it, obs_wr.size(), exp_wr.size());
            else pass_cnt++;
            foreach (exp_wr[i]) begin
                logic [23:0] got;
                got = (i < obs_wr.size()) ? obs_wr[i] : 24'hxxxxxx;
                chk_cnt++;
                if (got !== exp_wr[i]) $display("FAIL rand%0d_write%0d got %h required %h", it, i, got, exp_wr[i]);
                else pass_cnt++;
            end
            chk_cnt++;
            if ({op, error, overlap} !== {exp_run, exp_err, 1'b0})
                $display("FAIL rand%0d_end got op/err/ovl=%b required %b", it, {op, error, overlap}, {exp_run, exp_err, 1'b0});
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        do_abort();
        send_byte(8'h02, 0);
        send_byte(8'hC3, 0);
        send_byte(8'h5A, 0);
        #2;
        reset    = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk_cnt++;
        if ({rx_ready, write_memory, op, loading, error, user_address, in_data} !== {5'b10000, 24'h0})
            $display("FAIL midreset_outputs got %b required %b",
                     {rx_ready, write_memory, op, loading, error, user_address, in_data}, {5'b10000, 24'h0});
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        stim = '{8'h01, 8'($urandom), 8'($urandom), 8'($urandom_range(0, 15))};
        model();
        drive_stream(0, 0);
        chk_cnt++;
        if (obs_wr.size() != 1 || obs_wr[0] !== exp_wr[0] || op !== 1'b1)
            $display("FAIL midreset_restart got n=%0d op=%b required 1 write %h op=1", obs_wr.size(), op, exp_wr[0]);
        else pass_cnt++;
    endtask

    task automatic test_abort_b1();
        do_abort();
        send_byte(8'h02, 0);
        send_byte(8'h77, 0);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h03;
        abort    = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        rx_valid = 1'b0;
        chk_cnt++;
        if ({rx_ready, loading, error, op, user_address} !== {4'b1000, 4'd0})
            $display("FAIL abort_b1_state got rdy/load/err/op/addr=%b required 10000000",
                     {rx_ready, loading, error, op, user_address});
        else pass_cnt++;
        stim = '{8'h01, 8'($urandom), 8'($urandom), 8'($urandom_range(0, 15))};
        model();
        drive_stream(0, 0);
        chk_cnt++;
        if (obs_wr.size() != 1 || obs_wr[0] !== exp_wr[0] || op !== 1'b1)
            $display("FAIL abort_b1_restart got n=%0d op=%b required 1 write %h op=1", obs_wr.size(), op, exp_wr[0]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_header();
        test_bad_nibble();
        test_throttled();
        test_full();
        test_random();
        test_reset_mid();
        test_abort_b1();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
